// File: rtl/pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl
// Central stall/flush controller for a 5-stage pipeline (pc, if, id, ex, mem,
// wb). It resolves per-stage stall requests into a freeze vector, and turns
// exceptions/ERET reported by MEM into a one-cycle flush plus PC redirect.
// If a fetch is still outstanding when the exception arrives, the redirect is
// held back in WAIT_FETCH until the fetch bus is released.
//
// Ports
//   clk            : clock, rising edge
//   rst            : synchronous, active-high reset
//   stall_req_if   : fetch not complete (bus wait)
//   stall_req_id   : load-use / operand hazard in ID
//   stall_req_ex   : multi-cycle EX operation busy
//   stall_req_mem  : data bus wait in MEM
//   exc_req        : exception or ERET reported by MEM this cycle
//   exc_is_eret    : qualifies exc_req as ERET
//   cp0_epc        : current EPC from CP0
//   stall_out      : freeze vector {wb,mem,ex,id,if,pc}, bit0 = pc
//   flush          : one-cycle flush of all inter-stage registers
//   redirect_en    : PC load strobe, coincident with flush
//   redirect_pc    : PC target, zero when redirect_en=0
//   busy_wait      : high while waiting for the fetch to finish
//   stall_cycles   : free-running count of cycles with stall_out[0]=1
// ---------------------------------------------------------------------------
module pipeline_ctrl #(
  parameter int unsigned                 ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]       EXC_VECTOR = ADDR_WIDTH'(32'hBFC00380)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_req_if,
  input  logic                  stall_req_id,
  input  logic                  stall_req_ex,
  input  logic                  stall_req_mem,
  input  logic                  exc_req,
  input  logic                  exc_is_eret,
  input  logic [ADDR_WIDTH-1:0] cp0_epc,
  output logic [5:0]            stall_out,
  output logic                  flush,
  output logic                  redirect_en,
  output logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  busy_wait,
  output logic [31:0]           stall_cycles
);

  localparam int unsigned STALL_W = 6;
  localparam int unsigned CNT_W   = 32;

  localparam logic [STALL_W-1:0] STALL_NONE = STALL_W'(6'b000000);
  localparam logic [STALL_W-1:0] STALL_IF   = STALL_W'(6'b000011);
  localparam logic [STALL_W-1:0] STALL_ID   = STALL_W'(6'b000011);
  localparam logic [STALL_W-1:0] STALL_EX   = STALL_W'(6'b000111);
  localparam logic [STALL_W-1:0] STALL_MEM  = STALL_W'(6'b001111);
  localparam logic [STALL_W-1:0] STALL_ALL  = STALL_W'(6'b111111);

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_WAIT_FETCH = 2'd1,
    ST_REDIRECT   = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [ADDR_WIDTH-1:0]   r_target;
  logic [ADDR_WIDTH-1:0]   w_target_next;
  logic [CNT_W-1:0]        r_stall_cycles;

  logic [STALL_W-1:0]      w_stall_prio;
  logic [STALL_W-1:0]      w_stall;
  logic                    w_flush;
  logic                    w_redirect_en;
  logic [ADDR_WIDTH-1:0]   w_redirect_pc;
  logic                    w_busy_wait;
  logic [ADDR_WIDTH-1:0]   w_exc_target;

  // Deepest requesting stage wins; everything older than it is frozen.
  always_comb begin
    w_stall_prio = STALL_NONE;
    if (stall_req_mem)     w_stall_prio = STALL_MEM;
    else if (stall_req_ex) w_stall_prio = STALL_EX;
    else if (stall_req_id) w_stall_prio = STALL_ID;
    else if (stall_req_if) w_stall_prio = STALL_IF;
  end

  // Target chosen in the cycle the exception is reported.
  assign w_exc_target = exc_is_eret ? cp0_epc : EXC_VECTOR;

  // State, target and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_RUN;
      r_target       <= '0;
      r_stall_cycles <= '0;
    end else begin
      r_state  <= w_state_next;
      r_target <= w_target_next;
      if (w_stall[0]) r_stall_cycles <= r_stall_cycles + CNT_W'(1);
    end
  end

  // Next-state and control outputs. Flush always forces an empty stall vector.
  always_comb begin
    w_state_next  = r_state;
    w_target_next = r_target;
    w_stall       = STALL_NONE;
    w_flush       = 1'b0;
    w_redirect_en = 1'b0;
    w_redirect_pc = '0;
    w_busy_wait   = 1'b0;

    case (r_state)
      ST_RUN: begin
        if (exc_req) begin
          w_target_next = w_exc_target;
          if (stall_req_if) begin
            // Fetch still on the bus: freeze everything until it completes.
            w_stall      = STALL_ALL;
            w_state_next = ST_WAIT_FETCH;
          end else begin
            w_flush       = 1'b1;
            w_redirect_en = 1'b1;
            w_redirect_pc = w_exc_target;
          end
        end else begin
          w_stall = w_stall_prio;
        end
      end

      ST_WAIT_FETCH: begin
        // Only the fetch bus matters here; new exceptions and hazards are ignored.
        w_stall     = STALL_ALL;
        w_busy_wait = 1'b1;
        if (!stall_req_if) w_state_next = ST_REDIRECT;
      end

      ST_REDIRECT: begin
        w_flush       = 1'b1;
        w_redirect_en = 1'b1;
        w_redirect_pc = r_target;
        w_state_next  = ST_RUN;
      end

      default: begin
        w_state_next = ST_RUN;
      end
    endcase

    // Reset silences all control outputs regardless of state or inputs.
    if (rst) begin
      w_stall       = STALL_NONE;
      w_flush       = 1'b0;
      w_redirect_en = 1'b0;
      w_redirect_pc = '0;
      w_busy_wait   = 1'b0;
    end
  end

  assign stall_out    = w_stall;
  assign flush        = w_flush;
  assign redirect_en  = w_redirect_en;
  assign redirect_pc  = w_redirect_pc;
  assign busy_wait    = w_busy_wait;
  assign stall_cycles = r_stall_cycles;

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter EXC_VECTOR, default 32'hBFC00380, general exception entry address.
REQ-002 Parameter ADDR_WIDTH, default 32, PC/address width.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 stall_req_if  input  1  instruction fetch not complete (bus wait).
REQ-006 stall_req_id  input  1  load-use / operand hazard in ID.
REQ-007 stall_req_ex  input  1  multi-cycle EX op (mult/div) busy.
REQ-008 stall_req_mem  input  1  data bus wait in MEM.
REQ-009 exc_req  input  1  exception/eret reported by MEM stage this cycle.
REQ-010 exc_is_eret  input  1  qualifies exc_req as ERET.
REQ-011 cp0_epc  input  ADDR_WIDTH  current EPC value from CP0.
REQ-012 stall_out  output  6  stall vector {wb,mem,ex,id,if,pc}, bit0 = pc; drives stall_current_stage/stall_next_stage of the inter-stage registers.
REQ-013 flush  output  1  one-cycle flush of all inter-stage registers.
REQ-014 redirect_en  output  1  PC load strobe, coincident with flush.
REQ-015 redirect_pc  output  ADDR_WIDTH  PC target, valid when redirect_en=1.
REQ-016 busy_wait  output  1  high while in WAIT_FETCH state.
REQ-017 stall_cycles  output  32  count of cycles with stall_out[0]=1.

Function
REQ-018 Stall priority: highest requesting stage s in order mem>ex>id>if; stall_out bits pc..s = 1, bits above s = 0 (bubble enters stage s+1).
REQ-019 Stall mapping: mem -> 6'b001111; ex -> 6'b000111; id -> 6'b000011; if -> 6'b000001... SHALL be: if -> 6'b000011 (pc and if hold); no request -> 6'b000000.
REQ-020 FSM states: RUN, WAIT_FETCH, REDIRECT; encoding free.
REQ-021 RUN, exc_req=1, stall_req_if=0: flush=1, redirect_en=1 same cycle (combinational), stall_out=0; next state RUN.
REQ-022 RUN, exc_req=1, stall_req_if=1: latch target, stall_out=6'b111111, flush=0; next WAIT_FETCH.
REQ-023 Target: exc_is_eret=1 -> cp0_epc sampled that cycle; else EXC_VECTOR.
REQ-024 WAIT_FETCH: stall_out=6'b111111, busy_wait=1, exc_req and all other stall requests ignored; when stall_req_if=0 -> next REDIRECT.
REQ-025 REDIRECT: flush=1, redirect_en=1, redirect_pc=latched target, stall_out=0, one cycle; next RUN.
REQ-026 Flush dominates stalls: any cycle with flush=1 has stall_out=0, stall_req_ex/mem ignored.
REQ-027 redirect_pc = 0 whenever redirect_en=0.
REQ-028 stall_cycles increments by 1 each cycle stall_out[0]=1, wraps 32'hFFFFFFFF -> 0.
REQ-029 Back-to-back exc_req in consecutive RUN cycles each produce own flush pulse.
REQ-030 stall_out, flush, redirect_en, redirect_pc depend only on current state, latched target and current inputs; no extra latency in RUN.

Reset
REQ-031 rst=1 at a clock edge: state -> RUN, latched target -> 0, stall_cycles -> 0.
REQ-032 While rst=1: stall_out=0, flush=0, redirect_en=0, redirect_pc=0, busy_wait=0, regardless of inputs.
REQ-033 rst asserted in WAIT_FETCH or REDIRECT abandons pending redirect; no flush after release.

Verification
REQ-034 Priority: stall_req_id=1, stall_req_mem=1 -> stall_out=6'b001111; only id=1 -> 6'b000011; none -> 0.
REQ-035 Plain exception: RUN, exc_req=1, exc_is_eret=0, stall_req_ex=1 -> same cycle flush=1, redirect_pc=32'hBFC00380, stall_out=0.
REQ-036 ERET: cp0_epc=32'h8000_1234, exc_req=1, exc_is_eret=1 -> redirect_pc=32'h8000_1234, flush=1 one cycle.
REQ-037 Fetch pending: exc_req=1 with stall_req_if=1 held 3 cycles -> stall_out=6'b111111, busy_wait=1 for 3 cycles; cycle after if drops flush=1 with latched target; cp0_epc changes meanwhile not reflected.
REQ-038 Reset mid-wait: enter WAIT_FETCH, rst=1 one cycle, release with stall_req_if=0 -> no flush, state RUN, stall_cycles=0.
REQ-039 Counter: stall_req_mem=1 for 5 cycles from reset -> stall_cycles=5; preload near wrap via long run -> wraps to 0.
